// File: rtl/conf_pkt_gen_pkg.sv
// -----------------------------------------------------------------------------
// conf_pkt_gen_pkg
// Shared definitions for the host-side configuration packet generator:
// command op codes, flit-type codes, ethertype base, FSM state encoding and
// small flit-building helpers.
// -----------------------------------------------------------------------------
package conf_pkt_gen_pkg;

  // Command op codes as carried on cmd_op and in the ethertype low bits.
  typedef enum logic [1:0] {
    OP_RD_PROG = 2'd0,
    OP_WR_SEL  = 2'd1,
    OP_RD_SEL  = 2'd2,
    OP_WR_PROG = 2'd3
  } cmd_op_e;

  // Flit-type codes placed in flit bits [133:132].
  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b11,
    FLIT_TAIL = 2'b10
  } flit_type_e;

  localparam logic [7:0] ETHERTYPE_BASE = 8'h90;
  localparam logic [3:0] FLIT_MARK      = 4'hf;

  // Generator FSM; the state names the flit currently on data_out.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEAD    = 3'd1,
    ST_WORDS   = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_TAIL    = 3'd4,
    ST_GAPW    = 3'd5
  } state_e;

  // Wrap a 128-bit payload into a 134-bit flit.
  function automatic logic [133:0] make_flit(input flit_type_e ftype,
                                             input logic [127:0] payload);
    return {ftype, FLIT_MARK, payload};
  endfunction

  // Program-word payload: address in [47:16], data in [79:48].
  function automatic logic [127:0] word_payload(input logic [31:0] addr,
                                                input logic [31:0] data);
    return {48'h0, data, addr, 16'h0};
  endfunction

endpackage

// File: rtl/conf_word_fifo.sv
// -----------------------------------------------------------------------------
// conf_word_fifo
// Synchronous show-ahead FIFO holding {addr, data} program words.
// rd_data always presents the oldest entry; pop consumes it on the edge.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   push, push_data      write one entry (ignored when full)
//   pop                  consume the head entry (ignored when empty)
//   rd_data              head entry (show-ahead)
//   full, empty, count   occupancy status
// -----------------------------------------------------------------------------
module conf_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == CW'(0));
  assign count   = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/conf_pkt_gen.sv
// -----------------------------------------------------------------------------
// conf_pkt_gen
// Host-side configuration packet generator. Turns configuration commands into
// bubble-free 134-bit flit packets for the CPU configuration endpoint.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       command handshake (ready is combinational)
//   cmd_op, cmd_addr, cmd_wdata command fields; cmd_last closes a write packet
//   data_out_valid, data_out    flit stream (registered)
//   busy                        packet in flight or program words pending
//   pkt_count                   packets completed (wraps at 2^16)
// -----------------------------------------------------------------------------
module conf_pkt_gen
  import conf_pkt_gen_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [47:0] DMAC  = 48'h1111_2222_4444,
  parameter logic [47:0] SMAC  = 48'h1111_2222_3333,
  parameter int          GAP   = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [31:0]  cmd_addr,
  input  logic [31:0]  cmd_wdata,
  input  logic         cmd_last,
  output logic         data_out_valid,
  output logic [133:0] data_out,
  output logic         busy,
  output logic [15:0]  pkt_count
);

  localparam int         AW        = $clog2(DEPTH);
  localparam int         CW        = AW + 1;
  localparam logic [CW-1:0] LAST_FILL = CW'(DEPTH - 1);
  localparam bit         GAP_ZERO  = (GAP == 0);
  localparam logic [1:0] GAP_LAST  = 2'(GAP - 1);

  state_e        state_r;
  logic          is_write_r;
  logic [CW-1:0] words_left_r;
  logic [1:0]    gap_cnt_r;
  cmd_op_e       lat_op_r;
  logic [31:0]   lat_addr_r;
  logic          lat_sel_r;

  cmd_op_e       op_s;
  logic          ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          push_launch_s;
  logic          stall_flush_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [63:0]   fifo_rd_data_s;
  logic          word_is_tail_s;
  logic [133:0]  word_flit_s;
  logic [127:0]  body_payload_s;

  // Head flit for a given op: MAC addresses then ethertype 0x90/op.
  function automatic logic [133:0] head_flit(input cmd_op_e op);
    return make_flit(FLIT_HEAD, {DMAC, SMAC, ETHERTYPE_BASE, 6'h0, op, 16'h0});
  endfunction

  assign op_s     = cmd_op_e'(cmd_op);
  assign accept_s = cmd_valid & ready_s;
  assign push_s   = accept_s & (op_s == OP_WR_PROG);

  // The word that makes the FIFO full launches a packet just like cmd_last.
  assign push_launch_s = push_s & (cmd_last | (fifo_count_s == LAST_FILL));

  // A non-write op cannot overtake unflushed words: send them first.
  assign stall_flush_s = (state_r == ST_IDLE) & cmd_valid &
                         (op_s != OP_WR_PROG) & ~fifo_empty_s;

  // The head entry is popped on the edge that registers it into data_out.
  assign pop_s = ((state_r == ST_HEAD) & is_write_r) |
                 ((state_r == ST_WORDS) & (words_left_r != CW'(0)));

  assign word_is_tail_s = (words_left_r == CW'(1));
  assign word_flit_s    = make_flit(word_is_tail_s ? FLIT_TAIL : FLIT_BODY,
                                    word_payload(fifo_rd_data_s[63:32],
                                                 fifo_rd_data_s[31:0]));

  assign cmd_ready = ready_s;
  assign busy      = (state_r != ST_IDLE) | ~fifo_empty_s;

  // Command acceptance: only in IDLE; writes need room, other ops need an empty FIFO.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (op_s == OP_WR_PROG) begin
        ready_s = ~fifo_full_s;
      end else begin
        ready_s = fifo_empty_s;
      end
    end else begin
      ready_s = 1'b0;
    end
  end

  // Body payload of the three-flit packets, built from the latched command.
  always_comb begin
    body_payload_s = 128'h0;
    case (lat_op_r)
      OP_WR_SEL:  body_payload_s = {111'h0, lat_sel_r, 16'h0};
      OP_RD_PROG: body_payload_s = {80'h0, lat_addr_r, 16'h0};
      default:    body_payload_s = 128'h0;
    endcase
  end

  conf_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .push_data ({cmd_addr, cmd_wdata}),
    .pop       (pop_s),
    .rd_data   (fifo_rd_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Packet FSM with registered flit outputs and packet counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      is_write_r     <= 1'b0;
      words_left_r   <= CW'(0);
      gap_cnt_r      <= 2'd0;
      lat_op_r       <= OP_RD_PROG;
      lat_addr_r     <= 32'h0;
      lat_sel_r      <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= 134'h0;
      pkt_count      <= 16'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          data_out_valid <= 1'b0;
          data_out       <= 134'h0;
          if (push_launch_s) begin
            // Packet covers the words already queued plus the one pushed now.
            state_r        <= ST_HEAD;
            is_write_r     <= 1'b1;
            words_left_r   <= fifo_count_s + CW'(1);
            data_out_valid <= 1'b1;
            data_out       <= head_flit(OP_WR_PROG);
          end else if (stall_flush_s) begin
            state_r        <= ST_HEAD;
            is_write_r     <= 1'b1;
            words_left_r   <= fifo_count_s;
            data_out_valid <= 1'b1;
            data_out       <= head_flit(OP_WR_PROG);
          end else if (accept_s && (op_s != OP_WR_PROG)) begin
            state_r        <= ST_HEAD;
            is_write_r     <= 1'b0;
            lat_op_r       <= op_s;
            lat_addr_r     <= cmd_addr;
            lat_sel_r      <= cmd_wdata[0];
            data_out_valid <= 1'b1;
            data_out       <= head_flit(op_s);
          end
        end
        ST_HEAD: begin
          data_out_valid <= 1'b1;
          if (is_write_r) begin
            state_r      <= ST_WORDS;
            data_out     <= word_flit_s;
            words_left_r <= words_left_r - CW'(1);
            if (word_is_tail_s) begin
              pkt_count <= pkt_count + 16'd1;
            end
          end else begin
            state_r  <= ST_PAYLOAD;
            data_out <= make_flit(FLIT_BODY, body_payload_s);
          end
        end
        ST_WORDS: begin
          if (words_left_r != CW'(0)) begin
            data_out_valid <= 1'b1;
            data_out       <= word_flit_s;
            words_left_r   <= words_left_r - CW'(1);
            if (word_is_tail_s) begin
              pkt_count <= pkt_count + 16'd1;
            end
          end else begin
            // Tail already presented: close the packet.
            data_out_valid <= 1'b0;
            data_out       <= 134'h0;
            gap_cnt_r      <= 2'd0;
            state_r        <= GAP_ZERO ? ST_IDLE : ST_GAPW;
          end
        end
        ST_PAYLOAD: begin
          state_r        <= ST_TAIL;
          data_out_valid <= 1'b1;
          data_out       <= make_flit(FLIT_TAIL, 128'h0);
          pkt_count      <= pkt_count + 16'd1;
        end
        ST_TAIL: begin
          data_out_valid <= 1'b0;
          data_out       <= 134'h0;
          gap_cnt_r      <= 2'd0;
          state_r        <= GAP_ZERO ? ST_IDLE : ST_GAPW;
        end
        ST_GAPW: begin
          data_out_valid <= 1'b0;
          data_out       <= 134'h0;
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          data_out_valid <= 1'b0;
          data_out       <= 134'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conf_pkt_gen.sv
module tb_conf_pkt_gen;

  localparam int          DEPTH = 16;
  localparam int          GAP   = 1;
  localparam logic [47:0] DMAC  = 48'h1111_2222_4444;
  localparam logic [47:0] SMAC  = 48'h1111_2222_3333;

  logic         clk;
  logic         resetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         cmd_last;
  logic         data_out_valid;
  logic [133:0] data_out;
  logic         busy;
  logic [15:0]  pkt_count;

  int n_chk;
  int n_fail;

  // Reference model state
  logic [133:0] expq[$];
  logic [63:0]  pend[$];
  logic [15:0]  exp_pkts;

  // Monitor state
  bit in_pkt;
  bit seen_tail;
  int idle_cnt;

  conf_pkt_gen #(
    .DEPTH (DEPTH),
    .DMAC  (DMAC),
    .SMAC  (SMAC),
    .GAP   (GAP)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_last       (cmd_last),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [133:0] got, input logic [133:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [133:0] mk(input logic [1:0] t, input logic [127:0] p);
    return {t, 4'hf, p};
  endfunction

  function automatic logic [133:0] head(input logic [1:0] op);
    return mk(2'b01, {DMAC, SMAC, 8'h90, 6'h0, op, 16'h0});
  endfunction

  // Whole pending word list becomes one write packet, last word is the tail.
  task automatic model_flush();
    int n;
    n = pend.size();
    expq.push_back(head(2'd3));
    for (int i = 0; i < n; i++) begin
      expq.push_back(mk((i == n - 1) ? 2'b10 : 2'b11,
                        {48'h0, pend[i][31:0], pend[i][63:32], 16'h0}));
    end
    pend.delete();
  endtask

  task automatic model_accept(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic last);
    if (op == 2'd3) begin
      pend.push_back({addr, wdata});
      if (last || pend.size() == DEPTH) model_flush();
    end else begin
      expq.push_back(head(op));
      if (op == 2'd1)      expq.push_back(mk(2'b11, {111'h0, wdata[0], 16'h0}));
      else if (op == 2'd0) expq.push_back(mk(2'b11, {80'h0, addr, 16'h0}));
      else                 expq.push_back(mk(2'b11, 128'h0));
      expq.push_back(mk(2'b10, 128'h0));
    end
  endtask

  // Offer one command; waits counts cycles cmd_ready was low.
  task automatic send(input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic last, output int waits);
    bit acc;
    if (op != 2'd3 && pend.size() > 0) model_flush();
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_last = last; cmd_valid = 1'b1;
    acc = 1'b0;
    waits = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      acc = cmd_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
    end
    #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    if (acc) model_accept(op, addr, wdata, last);
    else fail("cmd_timeout", "cmd_ready never asserted");
  endtask

  task automatic grab(output logic [133:0] f, output logic v);
    @(negedge clk);
    f = data_out;
    v = data_out_valid;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (expq.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (expq.size() != 0) fail("drain_timeout", "expected flits never appeared");
    repeat (GAP + 3) @(negedge clk);
    chk("drain_busy", 134'(busy), 134'(1'b0));
  endtask

  // Every-cycle comparison of the flit stream against the model queue.
  always @(negedge clk) begin
    logic [133:0] e;
    if (!resetn) begin
      in_pkt = 1'b0;
      seen_tail = 1'b0;
      idle_cnt = 0;
    end else begin
      if (data_out_valid) begin
        if (expq.size() == 0) begin
          fail("unexpected_flit", $sformatf("got %h with nothing expected", data_out));
        end else begin
          e = expq.pop_front();
          chk("flit", data_out, e);
          if (e[133:132] == 2'b10) exp_pkts = exp_pkts + 16'd1;
        end
        if (data_out[133:132] == 2'b01) begin
          if (in_pkt) fail("head_in_packet", "head flit before previous tail");
          if (seen_tail) chk("gap_idle", 134'(idle_cnt >= GAP), 134'(1'b1));
          in_pkt = 1'b1;
        end else if (data_out[133:132] == 2'b10) begin
          in_pkt = 1'b0;
          seen_tail = 1'b1;
          idle_cnt = 0;
        end
      end else begin
        if (in_pkt) fail("bubble", "data_out_valid low inside a packet");
        idle_cnt++;
      end
      chk("pkt_count", 134'(pkt_count), 134'(exp_pkts));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [133:0] f;
    logic         v;
    int           w;
    logic [31:0]  da, db, dc;
    int           r;
    logic [1:0]   op;

    n_chk = 0; n_fail = 0; exp_pkts = 16'h0;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd1; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_last = 1'b0;
    #23;
    chk("rst_valid", 134'(data_out_valid), 134'(1'b0));
    chk("rst_data", data_out, 134'h0);
    chk("rst_pkt_count", 134'(pkt_count), 134'(16'h0));
    chk("rst_busy", 134'(busy), 134'(1'b0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 134'(cmd_ready), 134'(1'b1));

    // WR_SEL sel=1
    send(2'd1, 32'h0, 32'h1, 1'b0, w);
    grab(f, v);
    chk("wrsel_head_valid", 134'(v), 134'(1'b1));
    chk("wrsel_head_type", 134'(f[133:132]), 134'(2'b01));
    chk("wrsel_ethertype", 134'(f[31:16]), 134'(16'h9001));
    grab(f, v);
    chk("wrsel_body_valid", 134'(v), 134'(1'b1));
    chk("wrsel_body_type", 134'(f[133:132]), 134'(2'b11));
    chk("wrsel_sel_bit", 134'(f[16]), 134'(1'b1));
    grab(f, v);
    chk("wrsel_tail_valid", 134'(v), 134'(1'b1));
    chk("wrsel_tail_type", 134'(f[133:132]), 134'(2'b10));
    chk("wrsel_pkt_count", 134'(pkt_count), 134'(16'd1));
    grab(f, v);
    chk("wrsel_after_tail", 134'(v), 134'(1'b0));

    // RD_PROG addr 0x100
    send(2'd0, 32'h0000_0100, 32'h0, 1'b0, w);
    grab(f, v);
    chk("rdprog_head_valid", 134'(v), 134'(1'b1));
    chk("rdprog_ethertype", 134'(f[31:16]), 134'(16'h9000));
    grab(f, v);
    chk("rdprog_body_valid", 134'(v), 134'(1'b1));
    chk("rdprog_addr", 134'(f[47:16]), 134'(32'h0000_0100));
    grab(f, v);
    chk("rdprog_tail_valid", 134'(v), 134'(1'b1));
    chk("rdprog_tail_type", 134'(f[133:132]), 134'(2'b10));

    // Three program words, last on the third
    da = 32'hAAAA_0001; db = 32'hBBBB_0002; dc = 32'hCCCC_0003;
    send(2'd3, 32'h0, da, 1'b0, w);
    send(2'd3, 32'h4, db, 1'b0, w);
    send(2'd3, 32'h8, dc, 1'b1, w);
    grab(f, v);
    chk("wrprog_head_valid", 134'(v), 134'(1'b1));
    chk("wrprog_ethertype", 134'(f[31:16]), 134'(16'h9003));
    grab(f, v);
    chk("wrprog_w0_type", 134'(f[133:132]), 134'(2'b11));
    chk("wrprog_w0_data", 134'(f[79:48]), 134'(da));
    chk("wrprog_w0_addr", 134'(f[47:16]), 134'(32'h0));
    grab(f, v);
    chk("wrprog_w1_type", 134'(f[133:132]), 134'(2'b11));
    chk("wrprog_w1_data", 134'(f[79:48]), 134'(db));
    grab(f, v);
    chk("wrprog_w2_valid", 134'(v), 134'(1'b1));
    chk("wrprog_w2_type", 134'(f[133:132]), 134'(2'b10));
    chk("wrprog_w2_data", 134'(f[79:48]), 134'(dc));
    chk("wrprog_w2_addr", 134'(f[47:16]), 134'(32'h8));
    drain();

    // Auto-flush: DEPTH+3 words without last
    for (int i = 0; i < DEPTH + 3; i++) begin
      send(2'd3, 32'h1000 + 32'(i * 4), $urandom, 1'b0, w);
      if (i == DEPTH) chk("autoflush_ready_low", 134'(w >= DEPTH + 1 + GAP), 134'(1'b1));
    end
    repeat (10) @(negedge clk);
    chk("held_busy", 134'(busy), 134'(1'b1));
    chk("held_no_flit", 134'(data_out_valid), 134'(1'b0));
    send(2'd3, 32'h2000, $urandom, 1'b1, w);
    drain();

    // Pending words flushed ahead of a non-write op
    send(2'd3, 32'h40, $urandom, 1'b0, w);
    send(2'd3, 32'h44, $urandom, 1'b0, w);
    send(2'd2, 32'h0, 32'h0, 1'b0, w);
    chk("stall_ready_low", 134'(w >= 4 + GAP), 134'(1'b1));
    drain();

    // Randomized command mix
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      op = (r < 6) ? 2'd3 : 2'(r % 3);
      send(op, $urandom & 32'hFFFF_FFFC, $urandom, ($urandom_range(0, 4) == 0), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (pend.size() > 0) send(2'd3, 32'h3000, $urandom, 1'b1, w);
    drain();

    // Reset in the middle of a word burst
    for (int i = 0; i < 8; i++) send(2'd3, 32'h5000 + 32'(i * 4), $urandom, (i == 7), w);
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    expq.delete(); pend.delete(); exp_pkts = 16'h0;
    #1;
    chk("midrst_valid", 134'(data_out_valid), 134'(1'b0));
    chk("midrst_data", data_out, 134'h0);
    chk("midrst_pkt_count", 134'(pkt_count), 134'(16'h0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 134'(busy), 134'(1'b0));
    chk("post_rst_ready", 134'(cmd_ready), 134'(1'b1));
    send(2'd2, 32'h0, 32'h0, 1'b0, w);
    grab(f, v);
    chk("post_rst_head", f, head(2'd2));
    grab(f, v);
    chk("post_rst_body_type", 134'(f[133:132]), 134'(2'b11));
    grab(f, v);
    chk("post_rst_tail_type", 134'(f[133:132]), 134'(2'b10));
    chk("post_rst_pkt_count", 134'(pkt_count), 134'(16'd1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
